// File: rtl/c2c_sup_pkg.sv
// Shared state encoding and width helpers for the chip-to-chip link supervisor.
package c2c_sup_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_WAIT_UP = 3'd2,
    ST_UP      = 3'd3,
    ST_FAIL    = 3'd4
  } sup_state_e;

  localparam int RETRAIN_CNT_W = 8;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c2c_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module c2c_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/c2c_link_supervisor.sv
// Aurora C2C link supervisor: reset sequencing, channel-up wait with bounded
// retries, glitch-filtered loss detection, error counters and status LEDs.
module c2c_link_supervisor
  import c2c_sup_pkg::*;
#(
  parameter int NUM_LANES     = 2,
  parameter int NUM_LEDS      = 4,
  parameter int HOLD_CYCLES   = 128,
  parameter int UP_TIMEOUT    = 1000000,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRIES   = 0,
  parameter int HEARTBEAT_DIV = 25000000,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_LANES-1:0]     lane_up,
  input  logic                     channel_up,
  input  logic                     soft_err,
  input  logic                     hard_err,
  input  logic                     sw_retrain,
  input  logic                     clr_cnt,
  output logic                     pma_init,
  output logic                     reset_pb,
  output logic                     link_ok,
  output logic [2:0]               state,
  output logic [RETRAIN_CNT_W-1:0] retrain_cnt,
  output logic [ERR_CNT_W-1:0]     soft_err_cnt,
  output logic [ERR_CNT_W-1:0]     hard_err_cnt,
  output logic [NUM_LEDS-1:0]      led_out
);

  localparam int TIMER_W = max_int(cnt_width(HOLD_CYCLES), cnt_width(UP_TIMEOUT));
  localparam int HB_W    = cnt_width(HEARTBEAT_DIV);
  localparam int LOSS_W  = cnt_width(LOSS_FILTER);
  localparam int RETRY_W = cnt_width(MAX_RETRIES + 1);

  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(UP_TIMEOUT - 1);
  localparam logic [HB_W-1:0]    HB_LAST      = HB_W'(HEARTBEAT_DIV - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST    = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  sup_state_e          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [RETRY_W-1:0]  retry_inc;
  logic [HB_W-1:0]     hb_cnt_q, hb_cnt_d;
  logic                hb_q, hb_d;
  logic                pma_init_q, pma_init_d;
  logic                reset_pb_q, reset_pb_d;
  logic                link_ok_q, link_ok_d;
  logic                sticky_q, sticky_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  logic all_up;
  logic enter_hold;
  logic err_window;

  assign all_up     = channel_up & (&lane_up);
  assign err_window = (state_q == ST_WAIT_UP) || (state_q == ST_UP);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    loss_d    = '0;
    retry_d   = retry_q;
    retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

    unique case (state_q)
      ST_HOLD: begin
        if (timer_q == HOLD_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (timer_q == HOLD_LAST) state_d = ST_WAIT_UP;
      end
      ST_WAIT_UP: begin
        if (all_up) begin
          state_d = ST_UP;
          retry_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = ((MAX_RETRIES != 0) && (retry_inc == RETRY_MAX)) ? ST_FAIL : ST_HOLD;
        end
      end
      ST_UP: begin
        timer_d = '0;
        // hard_err bypasses the filter; both firing together is one HOLD entry.
        if (hard_err) begin
          state_d = ST_HOLD;
        end else if (!all_up) begin
          if (loss_q == LOSS_LAST) state_d = ST_HOLD;
          else                     loss_d  = loss_q + 1'b1;
        end
      end
      ST_FAIL: begin
        timer_d = '0;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    if (sw_retrain) begin
      state_d = ST_HOLD;
      retry_d = '0;
      timer_d = '0;
    end

    if (state_d != state_q) timer_d = '0;
  end

  assign enter_hold = (state_d == ST_HOLD) && (state_q != ST_HOLD);

  always_comb begin
    hb_cnt_d   = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + 1'b1;
    hb_d       = hb_q ^ (hb_cnt_q == HB_LAST);
    pma_init_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
    reset_pb_d = (state_d != ST_WAIT_UP) && (state_d != ST_UP);
    link_ok_d  = (state_d == ST_UP);
    sticky_d   = clr_cnt ? 1'b0 : (sticky_q | hard_err);

    led_d    = '0;
    led_d[0] = hb_d;
    led_d[1] = link_ok_d;
    led_d[2] = (state_d == ST_UP) ? 1'b0 : ((state_d == ST_FAIL) ? 1'b1 : hb_d);
    led_d[3] = sticky_d;
    // The modulo keeps the lane index in range even for unused LED slots.
    for (int i = 4; i < NUM_LEDS; i++) begin
      led_d[i] = ((i - 4) < NUM_LANES) ? lane_up[(i - 4) % NUM_LANES] : 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_HOLD;
      timer_q    <= '0;
      loss_q     <= '0;
      retry_q    <= '0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      pma_init_q <= 1'b1;
      reset_pb_q <= 1'b1;
      link_ok_q  <= 1'b0;
      sticky_q   <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      loss_q     <= loss_d;
      retry_q    <= retry_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      pma_init_q <= pma_init_d;
      reset_pb_q <= reset_pb_d;
      link_ok_q  <= link_ok_d;
      sticky_q   <= sticky_d;
      led_q      <= led_d;
    end
  end

  c2c_sat_counter #(.WIDTH(ERR_CNT_W)) u_soft_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (soft_err & err_window),
    .clr   (clr_cnt),
    .count (soft_err_cnt)
  );

  c2c_sat_counter #(.WIDTH(ERR_CNT_W)) u_hard_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (hard_err & err_window),
    .clr   (clr_cnt),
    .count (hard_err_cnt)
  );

  c2c_sat_counter #(.WIDTH(RETRAIN_CNT_W)) u_retrain_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (enter_hold),
    .clr   (1'b0),
    .count (retrain_cnt)
  );

  assign state    = state_q;
  assign pma_init = pma_init_q;
  assign reset_pb = reset_pb_q;
  assign link_ok  = link_ok_q;
  assign led_out  = led_q;

endmodule
